// File: rtl/pool_tile_scheduler_if.sv
// pool_tile_scheduler_if
// Bundles the three handshake groups around the pooling tile scheduler:
//   pixel stream    : pix_valid, pix_data -> scheduler, pix_ready <- scheduler
//   datapath        : pool_valid_in, pool_data_in, pool_mode <- scheduler,
//                     pool_valid_out, pool_data_out -> scheduler
//   result stream   : res_valid, res_data, res_row, res_col <- scheduler,
//                     res_ready -> scheduler
// The master modport is the scheduler side and the slave modport is the
// environment (pixel source, pooling datapath and result consumer).
interface pool_tile_scheduler_if #(
    parameter int IN_DATA_WIDTH  = 72,
    parameter int OUT_DATA_WIDTH = 32,
    parameter int TILE_IDX_W     = 4
);
    logic                      pix_valid;
    logic [7:0]                pix_data;
    logic                      pix_ready;

    logic                      pool_valid_in;
    logic [IN_DATA_WIDTH-1:0]  pool_data_in;
    logic [1:0]                pool_mode;
    logic                      pool_valid_out;
    logic [OUT_DATA_WIDTH-1:0] pool_data_out;

    logic                      res_valid;
    logic                      res_ready;
    logic [OUT_DATA_WIDTH-1:0] res_data;
    logic [TILE_IDX_W-1:0]     res_row;
    logic [TILE_IDX_W-1:0]     res_col;

    modport master (
        input  pix_valid, pix_data, pool_valid_out, pool_data_out, res_ready,
        output pix_ready, pool_valid_in, pool_data_in, pool_mode,
               res_valid, res_data, res_row, res_col
    );

    modport slave (
        output pix_valid, pix_data, pool_valid_out, pool_data_out, res_ready,
        input  pix_ready, pool_valid_in, pool_data_in, pool_mode,
               res_valid, res_data, res_row, res_col
    );
endinterface

// File: rtl/pool_tile_scheduler.sv
// pool_tile_scheduler
// Buffers an IMG_HEIGHT x IMG_WIDTH 8-bit image, then walks 3x3 windows with
// step 2 in both dimensions, sending one 72-bit window per tile to an external
// 2x2/stride-1 pooling datapath and returning each 32-bit result tagged with
// its tile coordinates.
// Ports:
//   clk, rst_n   : clock (rising edge) and asynchronous active-low reset
//   start        : begin a frame, only looked at in IDLE
//   mode_cfg     : pooling mode (0 MAX, 1 AVG, 2 MIN, 3 rejected)
//   busy         : high in every state except IDLE
//   done         : one-cycle pulse after the final result handshake
//   err          : one-cycle pulse when a start is rejected
//   bus          : pixel stream, datapath and result handshakes (master side)
module pool_tile_scheduler #(
    parameter int IMG_HEIGHT     = 5,
    parameter int IMG_WIDTH      = 5,
    parameter int IN_DATA_WIDTH  = 72,
    parameter int OUT_DATA_WIDTH = 32,
    parameter int TILE_IDX_W     = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [1:0]             mode_cfg,
    output logic                   busy,
    output logic                   done,
    output logic                   err,
    pool_tile_scheduler_if.master  bus
);

    localparam int NPIX   = IMG_HEIGHT * IMG_WIDTH;
    localparam int ADDR_W = $clog2(NPIX + 1);
    localparam int TR     = (IMG_HEIGHT - 1) / 2;
    localparam int TC     = (IMG_WIDTH - 1) / 2;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ISSUE,
        WAIT,
        OUT,
        FIN
    } state_t;

    state_t                    state_q, state_d;
    logic [1:0]                mode_q, mode_d;
    logic [ADDR_W-1:0]         pix_cnt_q, pix_cnt_d;
    logic [TILE_IDX_W-1:0]     tile_r_q, tile_r_d;
    logic [TILE_IDX_W-1:0]     tile_c_q, tile_c_d;
    logic [OUT_DATA_WIDTH-1:0] res_data_q, res_data_d;
    logic [TILE_IDX_W-1:0]     res_row_q, res_row_d;
    logic [TILE_IDX_W-1:0]     res_col_q, res_col_d;
    logic                      err_q, err_d;

    logic [7:0]                frame_q [NPIX];
    logic [IN_DATA_WIDTH-1:0]  window;
    logic [ADDR_W-1:0]         win_addr;

    logic start_ok;
    logic pix_beat;
    logic last_pix;
    logic res_hs;
    logic last_tile;

    assign start_ok  = start && (mode_cfg != 2'd3);
    assign pix_beat  = (state_q == LOAD) && bus.pix_valid;
    assign last_pix  = pix_beat && (pix_cnt_q == ADDR_W'(NPIX - 1));
    assign res_hs    = (state_q == OUT) && bus.res_ready;
    assign last_tile = (tile_r_q == TILE_IDX_W'(TR - 1)) &&
                       (tile_c_q == TILE_IDX_W'(TC - 1));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a tile costs ISSUE, WAIT and OUT, so with the
    // consumer always ready and a one-cycle datapath a window goes out
    // every third cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_ok) state_d = LOAD;
            LOAD:    if (last_pix) state_d = ISSUE;
            ISSUE:   state_d = WAIT;
            WAIT:    if (bus.pool_valid_out) state_d = OUT;
            OUT:     if (res_hs) state_d = last_tile ? FIN : ISSUE;
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs decoded from the state; the window is only presented while
    // issuing so the datapath bus is quiet otherwise.
    always_comb begin
        bus.pix_ready     = (state_q == LOAD);
        bus.pool_valid_in = (state_q == ISSUE);
        bus.pool_data_in  = (state_q == ISSUE) ? window : '0;
        bus.res_valid     = (state_q == OUT);
        busy              = (state_q != IDLE);
        done              = (state_q == FIN);
    end

    assign bus.pool_mode = mode_q;
    assign bus.res_data  = res_data_q;
    assign bus.res_row   = res_row_q;
    assign bus.res_col   = res_col_q;
    assign err           = err_q;

    // Counters, latched mode and captured result. The tile counters are
    // cleared on an accepted start rather than after the last tile, so
    // after a frame they harmlessly sit one row past the grid.
    always_comb begin
        mode_d     = mode_q;
        pix_cnt_d  = pix_cnt_q;
        tile_r_d   = tile_r_q;
        tile_c_d   = tile_c_q;
        res_data_d = res_data_q;
        res_row_d  = res_row_q;
        res_col_d  = res_col_q;
        err_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (mode_cfg == 2'd3) begin
                        err_d = 1'b1;
                    end else begin
                        mode_d    = mode_cfg;
                        pix_cnt_d = '0;
                        tile_r_d  = '0;
                        tile_c_d  = '0;
                    end
                end
            end
            LOAD: begin
                if (pix_beat) begin
                    pix_cnt_d = pix_cnt_q + ADDR_W'(1);
                end
            end
            WAIT: begin
                if (bus.pool_valid_out) begin
                    res_data_d = bus.pool_data_out;
                    res_row_d  = tile_r_q;
                    res_col_d  = tile_c_q;
                end
            end
            OUT: begin
                if (res_hs) begin
                    if (tile_c_q == TILE_IDX_W'(TC - 1)) begin
                        tile_c_d = '0;
                        tile_r_d = tile_r_q + TILE_IDX_W'(1);
                    end else begin
                        tile_c_d = tile_c_q + TILE_IDX_W'(1);
                    end
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q     <= 2'd0;
            pix_cnt_q  <= '0;
            tile_r_q   <= '0;
            tile_c_q   <= '0;
            res_data_q <= '0;
            res_row_q  <= '0;
            res_col_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            mode_q     <= mode_d;
            pix_cnt_q  <= pix_cnt_d;
            tile_r_q   <= tile_r_d;
            tile_c_q   <= tile_c_d;
            res_data_q <= res_data_d;
            res_row_q  <= res_row_d;
            res_col_q  <= res_col_d;
            err_q      <= err_d;
        end
    end

    // Frame buffer, raster order. No reset: every frame rewrites all of it
    // before any window is read.
    always_ff @(posedge clk) begin
        if (pix_beat) begin
            frame_q[pix_cnt_q] <= bus.pix_data;
        end
    end

    // Window gather: byte k is pixel (2*tr + k/3, 2*tc + k%3).
    always_comb begin
        window   = '0;
        win_addr = '0;
        for (int k = 0; k < 9; k++) begin
            win_addr = ADDR_W'((2 * int'(tile_r_q) + k / 3) * IMG_WIDTH +
                               2 * int'(tile_c_q) + k % 3);
            window[k*8 +: 8] = frame_q[win_addr];
        end
    end

endmodule

// File: tb/tb_pool_tile_scheduler.sv
// tb_pool_tile_scheduler
// Directed bench for pool_tile_scheduler on a 5x5 image holding 1..25 in
// raster order. A small behavioural pooling datapath with one cycle of
// latency answers each window; results are compared with hand-computed
// constants.
module tb_pool_tile_scheduler;

    localparam int H   = 5;
    localparam int W   = 5;
    localparam int IDW = 72;
    localparam int ODW = 32;
    localparam int TW  = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [1:0] mode_cfg = 2'd0;
    logic       busy;
    logic       done;
    logic       err;

    int checks = 0;
    int fails  = 0;

    pool_tile_scheduler_if #(
        .IN_DATA_WIDTH (IDW),
        .OUT_DATA_WIDTH(ODW),
        .TILE_IDX_W    (TW)
    ) bus ();

    pool_tile_scheduler #(
        .IMG_HEIGHT    (H),
        .IMG_WIDTH     (W),
        .IN_DATA_WIDTH (IDW),
        .OUT_DATA_WIDTH(ODW),
        .TILE_IDX_W    (TW)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .mode_cfg(mode_cfg),
        .busy    (busy),
        .done    (done),
        .err     (err),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Behavioural 2x2/stride-1 pooling over one 3x3 window.
    function automatic logic [7:0] pool4(input logic [7:0] a, input logic [7:0] b,
                                         input logic [7:0] c, input logic [7:0] d,
                                         input logic [1:0] m);
        logic [9:0] s;
        logic [7:0] r;
        s = {2'b00, a} + {2'b00, b} + {2'b00, c} + {2'b00, d};
        case (m)
            2'd0: begin
                r = a;
                if (b > r) r = b;
                if (c > r) r = c;
                if (d > r) r = d;
            end
            2'd1: r = s[9:2];
            2'd2: begin
                r = a;
                if (b < r) r = b;
                if (c < r) r = c;
                if (d < r) r = d;
            end
            default: r = 8'd0;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] pool_window(input logic [71:0] w, input logic [1:0] m);
        logic [7:0] b [9];
        for (int k = 0; k < 9; k++) b[k] = w[k*8 +: 8];
        return {pool4(b[4], b[5], b[7], b[8], m), pool4(b[3], b[4], b[6], b[7], m),
                pool4(b[1], b[2], b[4], b[5], m), pool4(b[0], b[1], b[3], b[4], m)};
    endfunction

    // Pooling datapath model, one cycle of latency.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.pool_valid_out <= 1'b0;
            bus.pool_data_out  <= '0;
        end else begin
            bus.pool_valid_out <= bus.pool_valid_in;
            bus.pool_data_out  <= pool_window(bus.pool_data_in, bus.pool_mode);
        end
    end

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, err, bus.pix_ready, bus.pool_valid_in, bus.res_valid} !== 6'b0) begin
            fails++;
            $display("[TB] FAIL reset_flags busy/done/err/pix_ready/pool_valid_in/res_valid=%b required 000000",
                     {busy, done, err, bus.pix_ready, bus.pool_valid_in, bus.res_valid});
        end
        checks++;
        if (bus.pool_data_in !== '0 || bus.pool_mode !== 2'd0 || bus.res_data !== '0 ||
            bus.res_row !== '0 || bus.res_col !== '0) begin
            fails++;
            $display("[TB] FAIL reset_data pool_data_in=%h pool_mode=%0d res_data=%h row=%0d col=%0d required all 0",
                     bus.pool_data_in, bus.pool_mode, bus.res_data, bus.res_row, bus.res_col);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_illegal_mode();
        start = 1'b1;
        mode_cfg = 2'd3;
        @(negedge clk);
        start = 1'b0;
        mode_cfg = 2'd0;
        checks++;
        if (err !== 1'b1 || busy !== 1'b0 || bus.pix_ready !== 1'b0) begin
            fails++;
            $display("[TB] FAIL illegal_pulse err=%b busy=%b pix_ready=%b required 1/0/0",
                     err, busy, bus.pix_ready);
        end
        @(negedge clk);
        checks++;
        if (err !== 1'b0 || busy !== 1'b0 || bus.pix_ready !== 1'b0) begin
            fails++;
            $display("[TB] FAIL illegal_after err=%b busy=%b pix_ready=%b required 0/0/0",
                     err, busy, bus.pix_ready);
        end
    endtask

    task automatic start_frame(input logic [1:0] m);
        start = 1'b1;
        mode_cfg = m;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || bus.pix_ready !== 1'b1 || bus.pool_mode !== m) begin
            fails++;
            $display("[TB] FAIL start_accept busy=%b pix_ready=%b pool_mode=%0d required 1/1/%0d",
                     busy, bus.pix_ready, bus.pool_mode, m);
        end
    endtask

    // Streams pixels 1..count (or 0xFF filler); gap inserts an idle cycle
    // before each beat, optionally with a start pulse that must be ignored.
    task automatic load_image(input int count, input bit gap, input bit poke_start, input bit junk);
        bit ready_ok = 1'b1;
        for (int p = 1; p <= count; p++) begin
            if (gap) begin
                bus.pix_valid = 1'b0;
                start = poke_start;
                mode_cfg = 2'd2;
                @(negedge clk);
                start = 1'b0;
                mode_cfg = 2'd0;
            end
            if (bus.pix_ready !== 1'b1) ready_ok = 1'b0;
            bus.pix_valid = 1'b1;
            bus.pix_data = junk ? 8'hFF : 8'(p);
            @(negedge clk);
        end
        bus.pix_valid = 1'b0;
        checks++;
        if (!ready_ok) begin
            fails++;
            $display("[TB] FAIL load_ready pix_ready dropped during LOAD required 1");
        end
        if (count == H * W) begin
            checks++;
            if (bus.pix_ready !== 1'b0 || bus.pool_valid_in !== 1'b1) begin
                fails++;
                $display("[TB] FAIL load_end pix_ready=%b pool_valid_in=%b required 0/1",
                         bus.pix_ready, bus.pool_valid_in);
            end
            checks++;
            if (bus.pool_data_in !== 72'h0D0C0B080706030201) begin
                fails++;
                $display("[TB] FAIL first_window pool_data_in=%h required 0d0c0b080706030201",
                         bus.pool_data_in);
            end
        end
    endtask

    // Consumes the four results of a frame (first window already issued).
    // stall_tile < 0 means no backpressure.
    task automatic run_tiles(input logic [1:0] m, input logic [31:0] e0, input logic [31:0] e1,
                             input logic [31:0] e2, input logic [31:0] e3,
                             input int stall_tile, input int stall_cycles);
        logic [31:0] expv [4];
        int n = 0;
        int issues = 1;
        int stall_left = stall_cycles;
        int stall_seen = 0;
        int hs_exp;
        bit mode_ok = 1'b1;
        expv[0] = e0;
        expv[1] = e1;
        expv[2] = e2;
        expv[3] = e3;
        bus.res_ready = 1'b1;
        for (int cyc = 0; cyc < 200 && n < 4; cyc++) begin
            @(negedge clk);
            if (bus.pool_mode !== m) mode_ok = 1'b0;
            if (bus.pool_valid_in === 1'b1) issues++;
            if (bus.res_valid === 1'b1) begin
                if (n == stall_tile && stall_left > 0) begin
                    bus.res_ready = 1'b0;
                    stall_left--;
                    stall_seen++;
                    checks++;
                    if (bus.res_data !== expv[n] || bus.res_row !== TW'(n / 2) ||
                        bus.res_col !== TW'(n % 2) || bus.pool_valid_in !== 1'b0) begin
                        fails++;
                        $display("[TB] FAIL stall_hold res_data=%h row=%0d col=%0d pool_valid_in=%b required %h/%0d/%0d/0",
                                 bus.res_data, bus.res_row, bus.res_col, bus.pool_valid_in,
                                 expv[n], n / 2, n % 2);
                    end
                end else begin
                    bus.res_ready = 1'b1;
                    hs_exp = 1 + 3 * n + ((stall_tile >= 0 && n >= stall_tile) ? stall_cycles : 0);
                    checks++;
                    if (bus.res_data !== expv[n]) begin
                        fails++;
                        $display("[TB] FAIL res_data tile %0d got %h required %h", n, bus.res_data, expv[n]);
                    end
                    checks++;
                    if (bus.res_row !== TW'(n / 2) || bus.res_col !== TW'(n % 2)) begin
                        fails++;
                        $display("[TB] FAIL res_coord tile %0d got (%0d,%0d) required (%0d,%0d)",
                                 n, bus.res_row, bus.res_col, n / 2, n % 2);
                    end
                    checks++;
                    if (cyc != hs_exp) begin
                        fails++;
                        $display("[TB] FAIL res_timing tile %0d at cycle %0d required %0d", n, cyc, hs_exp);
                    end
                    n++;
                end
            end else begin
                bus.res_ready = 1'b1;
            end
        end
        checks++;
        if (n != 4) begin
            fails++;
            $display("[TB] FAIL result_count got %0d required 4 (cycle budget expired)", n);
        end
        checks++;
        if (issues != 4) begin
            fails++;
            $display("[TB] FAIL issue_count got %0d required 4", issues);
        end
        checks++;
        if (stall_seen != stall_cycles) begin
            fails++;
            $display("[TB] FAIL stall_cycles got %0d required %0d", stall_seen, stall_cycles);
        end
        checks++;
        if (!mode_ok) begin
            fails++;
            $display("[TB] FAIL pool_mode_stable got %0d required %0d", bus.pool_mode, m);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || busy !== 1'b1) begin
            fails++;
            $display("[TB] FAIL done_pulse done=%b busy=%b required 1/1", done, busy);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || bus.res_valid !== 1'b0 || bus.pool_valid_in !== 1'b0) begin
            fails++;
            $display("[TB] FAIL after_done done=%b busy=%b res_valid=%b pool_valid_in=%b required 0/0/0/0",
                     done, busy, bus.res_valid, bus.pool_valid_in);
        end
    endtask

    task automatic test_max();
        start_frame(2'd0);
        load_image(H * W, 1'b0, 1'b0, 1'b0);
        run_tiles(2'd0, 32'h0D0C0807, 32'h0F0E0A09, 32'h17161211, 32'h19181413, -1, 0);
    endtask

    task automatic test_min();
        start_frame(2'd2);
        load_image(H * W, 1'b0, 1'b0, 1'b0);
        run_tiles(2'd2, 32'h07060201, 32'h09080403, 32'h11100C0B, 32'h13120E0D, -1, 0);
    endtask

    task automatic test_avg();
        start_frame(2'd1);
        load_image(H * W, 1'b0, 1'b0, 1'b0);
        run_tiles(2'd1, 32'h0A090504, 32'h0C0B0706, 32'h14130F0E, 32'h16151110, -1, 0);
    endtask

    task automatic test_backpressure();
        start_frame(2'd0);
        load_image(H * W, 1'b0, 1'b0, 1'b0);
        run_tiles(2'd0, 32'h0D0C0807, 32'h0F0E0A09, 32'h17161211, 32'h19181413, 1, 10);
    endtask

    task automatic test_pix_gaps();
        start_frame(2'd0);
        load_image(H * W, 1'b1, 1'b1, 1'b0);
        run_tiles(2'd0, 32'h0D0C0807, 32'h0F0E0A09, 32'h17161211, 32'h19181413, -1, 0);
    endtask

    task automatic test_reset_midframe();
        start_frame(2'd1);
        load_image(12, 1'b0, 1'b0, 1'b1);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, err, bus.pix_ready, bus.pool_valid_in, bus.res_valid} !== 6'b0 ||
            bus.pool_mode !== 2'd0 || bus.res_data !== '0) begin
            fails++;
            $display("[TB] FAIL midframe_reset flags=%b pool_mode=%0d res_data=%h required 000000/0/0",
                     {busy, done, err, bus.pix_ready, bus.pool_valid_in, bus.res_valid},
                     bus.pool_mode, bus.res_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        start_frame(2'd0);
        load_image(H * W, 1'b0, 1'b0, 1'b0);
        run_tiles(2'd0, 32'h0D0C0807, 32'h0F0E0A09, 32'h17161211, 32'h19181413, -1, 0);
    endtask

    initial begin
        bus.pix_valid = 1'b0;
        bus.pix_data  = 8'd0;
        bus.res_ready = 1'b1;
        $display("[TB] pool_tile_scheduler directed test start");
        test_reset();
        test_illegal_mode();
        test_max();
        test_min();
        test_avg();
        test_backpressure();
        test_pix_gaps();
        test_reset_midframe();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/pool_tile_scheduler.md
# pool_tile_scheduler

Sequencer that feeds the 2x2/stride-1 pooling datapath from a buffered image. It accepts an IMG_HEIGHT x IMG_WIDTH 8-bit image as a pixel stream and stores it in an internal frame buffer. It then walks 3x3 windows with step 2 in both dimensions, issuing one 72-bit window per tile to the pooling datapath. Each returned 32-bit result (four pooled bytes) is delivered on a valid/ready result port tagged with its tile coordinates.

## Interface
- IMG_HEIGHT, 5, image rows; odd, >= 3
- IMG_WIDTH, 5, image columns; odd, >= 3
- IN_DATA_WIDTH, 72, window width to datapath (9 x 8-bit)
- OUT_DATA_WIDTH, 32, result width from datapath (4 x 8-bit)
- TILE_IDX_W, 4, width of tile row/col tags; must hold (IMG_*-1)/2-1
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin a frame; sampled only in IDLE
- mode_cfg  in  2  0 MAX, 1 AVG, 2 MIN, 3 illegal; latched on accepted start
- pix_valid  in  1  pixel stream valid
- pix_data  in  8  pixel, raster order (row 0 col 0 first)
- pix_ready  out  1  high only in LOAD
- pool_valid_in  out  1  window valid to datapath, one-cycle pulse
- pool_data_in  out  IN_DATA_WIDTH  window; byte k = pixel (r0+k/3, c0+k%3)
- pool_mode  out  2  latched mode, held stable for the whole frame
- pool_valid_out  in  1  datapath result valid
- pool_data_out  in  OUT_DATA_WIDTH  datapath result
- res_valid  out  1  result available
- res_ready  in  1  result consumer ready
- res_data  out  OUT_DATA_WIDTH  captured pooled bytes: [7:0] top-left, [15:8] top-right, [23:16] bottom-left, [31:24] bottom-right
- res_row, res_col  out  TILE_IDX_W  tile coordinates of res_data
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse after final result handshake
- err  out  1  one-cycle pulse: start rejected (mode_cfg=3)

## Operation
- Tile grid: TR=(IMG_HEIGHT-1)/2 rows by TC=(IMG_WIDTH-1)/2 columns. Tile (tr,tc) has origin r0=2*tr, c0=2*tc. Together the tiles produce the full (H-1)x(W-1) stride-1 pooled map.
- States: IDLE, LOAD, ISSUE, WAIT, OUT, FIN.
- IDLE: start=1 with mode_cfg!=3 latches the mode, clears the pixel count, and moves to LOAD. start=1 with mode_cfg=3 pulses err and stays in IDLE.
- LOAD: each pix_valid&pix_ready beat writes pix_data to the buffer at the count, then increments the count. The beat at count H*W-1 moves to ISSUE with tile (0,0).
- ISSUE: drive pool_valid_in=1 and pool_data_in for the current tile for exactly one cycle, then go to WAIT.
- WAIT: on pool_valid_out=1, capture pool_data_out into res_data and the tile indices into res_row/res_col, then go to OUT. With no pool_valid_out, remain in WAIT.
- OUT: hold res_valid=1 and all res_* stable until res_ready=1. On the handshake, advance the tile row-major (tc++, wrap to 0 with tr++). Go to ISSUE, or to FIN after tile (TR-1,TC-1).
- FIN: pulse done=1 for one cycle, return to IDLE.
- start is ignored outside IDLE. pool_valid_out outside WAIT is ignored.
- Buffer contents are not cleared between frames. Each frame fully overwrites the buffer.

## Timing
- Reset: state IDLE; pix_ready, pool_valid_in, pool_data_in, pool_mode, res_valid, res_data, res_row, res_col, busy, done, err all 0; pixel and tile counters 0.
- start accepted at edge t: busy=1 and pix_ready=1 from t+1.
- Last pixel accepted at edge t: pix_ready=0 and pool_valid_in=1 in cycle t+1.
- Datapath latency is 1 cycle: pool_valid_in in cycle t gives pool_valid_out in t+1, and res_valid rises in t+2.
- With res_ready held high, tiles issue every 3 cycles.
- The done pulse occurs in the cycle after the final res handshake; busy falls with it (busy=0 the cycle after FIN).
- Reset asserted mid-frame: immediate return to reset values; a partially loaded frame is discarded.

## Test plan
- 5x5 image, pixels 1..25 raster, MAX:
  - first window pool_data_in=0x0D0C0B080706030201
  - tile (0,0) res_data=0x0D0C0807
  - tile (1,1) res_data=0x19181413
  - exactly 4 results in order (0,0),(0,1),(1,0),(1,1), then done pulse.
- Same image, MIN: tile (0,0) res_data=0x07060201. AVG: tile (0,0) res_data=0x0A090504; pool_mode stays 1 the whole frame.
- start with mode_cfg=3: err=1 for one cycle, busy stays 0, pix_ready stays 0.
- Backpressure: hold res_ready=0 for 10 cycles on tile (0,1). res_valid and res_data stay stable, no further pool_valid_in occurs, and the tile resumes on release.
- pix_valid toggling every other cycle during LOAD: all 25 pixels stored correctly (MAX results match the first scenario). start pulses during LOAD are ignored.
- Reset asserted after 12 pixels, then a fresh start and a full 5x5 load: outputs return to 0 immediately and results match the first scenario.
